// File: rtl/spi_io_ctrl.sv
// spi_io_ctrl: Z180 I/O-mapped SPI master (mode 0, MSB first) with data, control/status and divider ports.
// Build option SPI_WAIT_EN: stall the CPU via waiting on data-port accesses during a transfer.
module spi_io_ctrl #(
    parameter logic [7:0] BASE_PORT = 8'h40,
    parameter logic [7:0] DIV_RESET = 8'd3
) (
    input  logic       PHI,
    input  logic       nRESET,
    input  logic [7:0] A,
    input  logic [7:0] D,
    input  logic       IORQ,
    input  logic       RD,
    input  logic       WR,
    input  logic       M1,
    output logic [7:0] data_out,
    output logic       data_en,
    output logic       waiting,
    output logic       SPI_SDO,
    input  logic       SPI_SDI,
    output logic       SPI_SCK,
    output logic       SPI_SS,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_t;

    state_t     state, state_nxt;
    logic [7:0] div, div_lat, divcnt, shreg, rx, offs;
    logic [2:0] bitcnt;
    logic       rx_valid, ovr, ss_en, done, sck, sdo;
    logic       busy, hit, sel_data, sel_ctrl, sel_div;
    logic       act, wr_acc, rd_acc, start, tick;

    // CPU access handshake: an access is "offered" while hit is high and is
    // actioned on the first PHI edge where waiting is low; done keeps the side
    // effects to once per access until IORQ is released.
    assign offs     = A - BASE_PORT;
    assign hit      = !IORQ && M1 && (offs < 8'd3) && (!RD || !WR);
    assign sel_data = (offs == 8'd0);
    assign sel_ctrl = (offs == 8'd1);
    assign sel_div  = (offs == 8'd2);
    assign busy     = (state != IDLE);

`ifdef SPI_WAIT_EN
    assign waiting = hit && sel_data && busy;
`else
    assign waiting = 1'b0;
`endif

    assign act     = hit && !done && !waiting;
    assign wr_acc  = act && !WR;
    assign rd_acc  = act && WR;
    assign start   = wr_acc && sel_data && !busy;
    assign data_en = hit && !RD && !waiting;
    assign tick    = (divcnt == div_lat);

    always_comb begin
        data_out = 8'h00;
        if (sel_data)
            data_out = rx;
        else if (sel_ctrl)
            data_out = {rx_valid, ovr, 4'b0000, ss_en, busy};
        else if (sel_div)
            data_out = div;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOW;
            LOW:     if (tick) state_nxt = HIGH;
            HIGH:    if (tick) state_nxt = (bitcnt == 3'd7) ? IDLE : LOW;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PHI or negedge nRESET) begin
        if (!nRESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge PHI or negedge nRESET) begin
        if (!nRESET) begin
            div      <= DIV_RESET;
            div_lat  <= DIV_RESET;
            divcnt   <= 8'h00;
            shreg    <= 8'h00;
            rx       <= 8'h00;
            bitcnt   <= 3'd0;
            rx_valid <= 1'b0;
            ovr      <= 1'b0;
            ss_en    <= 1'b0;
            done     <= 1'b0;
            sck      <= 1'b0;
            sdo      <= 1'b0;
        end else begin
            if (IORQ)
                done <= 1'b0;
            else if (act)
                done <= 1'b1;
            if (wr_acc && sel_ctrl) begin
                ss_en <= D[0];
                if (D[6])
                    ovr <= 1'b0;
            end
            if (wr_acc && sel_div)
                div <= D;
`ifndef SPI_WAIT_EN
            if (wr_acc && sel_data && busy)
                ovr <= 1'b1;
`endif
            if (rd_acc && sel_data && !busy)
                rx_valid <= 1'b0;
            // Shift register transmits from bit 7 and receives into bit 0.
            case (state)
                IDLE: if (start) begin
                    shreg   <= D;
                    sdo     <= D[7];
                    bitcnt  <= 3'd0;
                    divcnt  <= 8'h00;
                    div_lat <= div;
                end
                LOW: if (tick) begin
                    divcnt <= 8'h00;
                    sck    <= 1'b1;
                    shreg  <= {shreg[6:0], SPI_SDI};
                end else begin
                    divcnt <= divcnt + 8'd1;
                end
                HIGH: if (tick) begin
                    divcnt <= 8'h00;
                    sck    <= 1'b0;
                    if (bitcnt == 3'd7) begin
                        rx       <= shreg;
                        rx_valid <= 1'b1;
                    end else begin
                        sdo    <= shreg[7];
                        bitcnt <= bitcnt + 3'd1;
                    end
                end else begin
                    divcnt <= divcnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign SPI_SCK   = sck;
    assign SPI_SDO   = sdo;
    assign SPI_SS    = !ss_en;
    assign state_dbg = state;
endmodule
